// File: rtl/en_strobe_gen_pkg.sv
// ============================================================================
// Module      : en_strobe_pkg
// Description : Shared types and default widths for the EN/MAX enable-count
//               strobe generator and its prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package en_strobe_pkg;

  // Default widths of the period divider and of the wrap target/counter.
  localparam int c_DIV_W_DEFAULT = 8;
  localparam int c_CNT_W_DEFAULT = 8;

  // Controller states. The encoding is fixed so that it can be probed
  // externally with stable values.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  // BUSY covers every state except IDLE.
  function automatic logic state_busy(input state_t s);
    return (s != IDLE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/en_strobe_gen_prescaler.sv
// ============================================================================
// Module      : en_prescaler
// Description : DIV_W-wide down-counter that produces the strobe tick.
//               While run is high it counts down every clock. When it is at
//               zero it raises tick for that cycle and reloads load_val.
//               A load request overrides counting and presets the counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module en_prescaler
  import en_strobe_pkg::*;
#(
  parameter int DIV_W = c_DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             run,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);

  // The tick is only meaningful while the controller is running.
  assign tick = run && w_zero;

  // Down-counter with a preset on load and an automatic reload on reaching zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (run) begin
      r_cnt <= w_zero ? load_val : (r_cnt - DIV_W'(1));
    end
  end

endmodule

`default_nettype wire

// File: rtl/en_strobe_gen.sv
// ============================================================================
// Module      : en_strobe_gen
// Description : Producer side of the EN/MAX enable-count interface. Emits
//               one-cycle EN strobes every DIV+1 clocks, counts MAX pulses
//               returned alongside EN, and pulses DONE once the programmed
//               number of wraps has been seen.
//               Build option EN_STROBE_AUTORELOAD_EN: when defined, the
//               completion state restarts a new batch instead of returning
//               to IDLE, so the block runs until STOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module en_strobe_gen
  import en_strobe_pkg::*;
#(
  parameter int DIV_W = c_DIV_W_DEFAULT,
  parameter int CNT_W = c_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic             STOP,
  input  logic [DIV_W-1:0] DIV,
  input  logic [CNT_W-1:0] WRAPS,
  input  logic             MAX,
  output logic             EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] WRAP_CNT
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [DIV_W-1:0] r_div_q;
  logic [CNT_W-1:0] r_wraps_q;
  logic [CNT_W-1:0] r_wrap_cnt;
  logic             r_en;
  logic             r_done;

  logic             w_accept;
  logic             w_count;
  logic             w_last;
  logic             w_sat;
  logic             w_en_nxt;
  logic             w_done_nxt;

  logic             w_pre_load;
  logic [DIV_W-1:0] w_pre_val;
  logic             w_pre_run;
  logic             w_tick;

  // START is honoured only from IDLE; any other state ignores it.
  assign w_accept = (r_state == IDLE) && START;

  // A MAX pulse counts only when it coincides with our own EN strobe. STOP
  // takes priority, so an aborting edge leaves the wrap count untouched.
  assign w_count = (r_state == RUN) && r_en && MAX && !STOP;

  // Compare one bit wider so an all-ones count cannot alias onto zero.
  assign w_last = w_count &&
                  (({1'b0, r_wrap_cnt} + (CNT_W+1)'(1)) == {1'b0, r_wraps_q});

  assign w_sat     = &r_wrap_cnt;
  assign w_pre_run = (r_state == RUN);

  en_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .load     (w_pre_load),
    .load_val (w_pre_val),
    .run      (w_pre_run),
    .tick     (w_tick)
  );

  // Next-state, strobe and prescaler-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b0;
    w_pre_load  = 1'b0;
    w_pre_val   = r_div_q;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          // The live DIV is used here because div_q only updates on this edge.
          w_pre_load  = 1'b1;
          w_pre_val   = DIV;
          w_state_nxt = (WRAPS == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (STOP) begin
          w_state_nxt = IDLE;
        end else if (w_last || (r_wraps_q == '0)) begin
          // A zero target only reaches RUN through the autoreload path and
          // completes immediately.
          w_state_nxt = FIN;
        end else begin
          w_en_nxt = w_tick;
        end
      end
      FIN: begin
`ifdef EN_STROBE_AUTORELOAD_EN
        w_state_nxt = RUN;
        w_pre_load  = 1'b1;
`else
        w_state_nxt = IDLE;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // DONE is high for exactly the one cycle spent in FIN.
    w_done_nxt = (w_state_nxt == FIN);
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the run configuration on an accepted START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_q   <= '0;
      r_wraps_q <= '0;
    end else if (w_accept) begin
      r_div_q   <= DIV;
      r_wraps_q <= WRAPS;
    end
  end

  // Registered EN and DONE strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_en   <= w_en_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Wrap counter: cleared whenever a batch starts, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap_cnt <= '0;
    end else if (w_pre_load) begin
      r_wrap_cnt <= '0;
    end else if (w_count && !w_sat) begin
      r_wrap_cnt <= r_wrap_cnt + CNT_W'(1);
    end
  end

  assign EN       = r_en;
  assign DONE     = r_done;
  assign BUSY     = state_busy(r_state);
  assign WRAP_CNT = r_wrap_cnt;

endmodule

`default_nettype wire

// File: tb/tb_en_strobe_gen.sv
// ============================================================================
// Module      : tb_en_strobe_gen
// Description : Self-checking bench for en_strobe_gen. Expected EN, DONE,
//               BUSY and WRAP_CNT are derived per cycle from closed-form
//               timing of a run (strobe n at START+n*(DIV+1), completion one
//               edge after the last strobe). A small downstream counter
//               returns MAX on every M-th EN, and noise is driven on MAX
//               while EN is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_en_strobe_gen;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       START = 1'b0;
  logic       STOP  = 1'b0;
  logic [7:0] DIV   = 8'd0;
  logic [7:0] WRAPS = 8'd0;
  logic       MAX;
  logic       EN;
  logic       BUSY;
  logic       DONE;
  logic [7:0] WRAP_CNT;

  logic ds_clr = 1'b0;
  logic noise  = 1'b0;
  int   ds_cnt = 0;
  int   ds_mod = 1;

  int checks   = 0;
  int failures = 0;

  en_strobe_gen #(
    .DIV_W (8),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .START    (START),
    .STOP     (STOP),
    .DIV      (DIV),
    .WRAPS    (WRAPS),
    .MAX      (MAX),
    .EN       (EN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .WRAP_CNT (WRAP_CNT)
  );

  always #5 clk = ~clk;

  // Downstream enable-gated counter: terminal pulse on every ds_mod-th EN.
  always @(posedge clk) begin
    if (ds_clr) ds_cnt <= 0;
    else if (EN === 1'b1) ds_cnt <= (ds_cnt == ds_mod - 1) ? 0 : ds_cnt + 1;
  end

  assign MAX = (EN === 1'b1) ? (ds_cnt == ds_mod - 1) : noise;

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int t, input logic e_en,
                           input logic e_done, input logic e_busy, input int e_wrap);
    check($sformatf("%s_EN@t%0d", tag, t), 32'(EN), 32'(e_en));
    check($sformatf("%s_DONE@t%0d", tag, t), 32'(DONE), 32'(e_done));
    check($sformatf("%s_BUSY@t%0d", tag, t), 32'(BUSY), 32'(e_busy));
    check($sformatf("%s_WRAP@t%0d", tag, t), 32'(WRAP_CNT), 32'(e_wrap));
  endtask

  // Strobes sampled by the DUT up to and including edge x after START.
  function automatic int strobes_by(input int x, input int d, input int n_tot);
    int s;
    if (x < 1) return 0;
    s = (x - 1) / (d + 1);
    return (s > n_tot) ? n_tot : s;
  endfunction

  task automatic start_cmd(input int d, input int w, input int m);
    @(negedge clk);
    START  = 1'b1;
    DIV    = 8'(d);
    WRAPS  = 8'(w);
    ds_mod = m;
    ds_clr = 1'b1;
    @(posedge clk);
    #1;
    START  = 1'b0;
    ds_clr = 1'b0;
    DIV    = 8'($urandom);
    WRAPS  = 8'($urandom);
  endtask

  // One-shot run. stop_sel: 0 = none, -1 = on the completing edge, >0 = edge.
  task automatic do_run(input string tag, input int d, input int w, input int m,
                        input int stop_sel, output int n_en);
    int   n_tot, t_end, s, e_wrap;
    logic e_en, e_done, e_busy;
    n_tot = w * m;
    t_end = (w == 0) ? 0 : n_tot * (d + 1) + 1;
    s     = (w == 0) ? 0 : ((stop_sel < 0) ? t_end : stop_sel);
    n_en  = 0;
    start_cmd(d, w, m);
    for (int t = 0; t <= t_end + 2; t++) begin
      @(negedge clk);
      if (s > 0 && t >= s) begin
        e_en = 1'b0; e_done = 1'b0; e_busy = 1'b0;
        e_wrap = strobes_by(s - 1, d, n_tot) / m;
      end else begin
        e_en   = (w > 0) && (t >= 1) && (t % (d + 1) == 0) && (t / (d + 1) <= n_tot);
        e_done = (t == t_end);
        e_busy = (t <= t_end);
        e_wrap = (w == 0) ? 0 : strobes_by(t, d, n_tot) / m;
      end
      if (EN === 1'b1) n_en++;
      check_all(tag, t, e_en, e_done, e_busy, e_wrap);
      STOP  = (s > 0) && (t + 1 == s);
      noise = 1'($urandom);
      START = (t < t_end) && (s == 0 || t < s) && ($urandom_range(0, 3) == 0);
      if (START) begin
        DIV   = 8'($urandom);
        WRAPS = 8'($urandom);
      end
    end
    START = 1'b0;
    STOP  = 1'b0;
    noise = 1'b0;
  endtask

  initial begin
    int n_en, d, w, m, r, s;

    // Reset state, asserted at time zero and then released.
    #1;
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("idle", 0, 1'b0, 1'b0, 1'b0, 0);

`ifdef EN_STROBE_AUTORELOAD_EN
    // Autoreload: WRAPS=1, every EN carries MAX, so each strobe completes a batch.
    d = int'($urandom_range(0, 3));
    s = d + 1 + 3 * (d + 3) + 1;
    start_cmd(d, 1, 1);
    for (int t = 0; t <= s + 2; t++) begin
      int   u;
      logic e_en, e_done;
      @(negedge clk);
      u = t - (d + 1);
      if (t >= s) begin
        check_all("auto", t, 1'b0, 1'b0, 1'b0, 0);
      end else begin
        e_en   = (u >= 0) && (u % (d + 3) == 0);
        e_done = (u >= 0) && (u % (d + 3) == 1);
        check_all("auto", t, e_en, e_done, 1'b1, e_done ? 1 : 0);
      end
      STOP  = (t + 1 == s);
      noise = 1'($urandom);
      START = (t < s) && ($urandom_range(0, 3) == 0);
      if (START) begin
        DIV   = 8'($urandom);
        WRAPS = 8'($urandom);
      end
    end
    START = 1'b0;
    STOP  = 1'b0;
    noise = 1'b0;
`else
    // Period and latency: strobe every 4 clocks, first after edge 4.
    do_run("period", 3, 2, 1, 0, n_en);
    check("period_en_count", 32'(n_en), 32'd2);

    // Completion with DIV=0, MAX on every 4th EN: eight strobes, WRAP_CNT=2.
    do_run("complete", 0, 2, 4, 0, n_en);
    check("complete_en_count", 32'(n_en), 32'd8);

    // Zero wrap target: immediate DONE with no strobes.
    do_run("wraps0", 2, 0, 1, 0, n_en);
    check("wraps0_en_count", 32'(n_en), 32'd0);

    // STOP on the edge that would have completed the run.
    do_run("stopfinal", 1, 2, 2, -1, n_en);

    // Randomised runs, some aborted at a random edge.
    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(0, 3));
      w = int'($urandom_range(0, 3));
      m = int'($urandom_range(1, 3));
      s = 0;
      if (w > 0 && $urandom_range(0, 2) == 0)
        s = int'($urandom_range(1, w * m * (d + 1) + 1));
      do_run($sformatf("rand%0d", i), d, w, m, s, n_en);
    end
`endif

    // Asynchronous reset in the middle of a run, after at least one wrap.
    start_cmd(2, 3, 2);
    r = int'($urandom_range(8, 12));
    repeat (r - 1) @(posedge clk);
    #3;
    check("pre_reset_busy", 32'(BUSY), 32'd1);
    check("pre_reset_wrap_nonzero", 32'(WRAP_CNT != 8'd0), 32'd1);
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    check_all("held_rst", 1, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all("post_rst", 2, 1'b0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
